output_port_fifo: RTL and testbench

OUTPUT_PORT_FIFO -- requirements
Module: output_port_fifo

---
 rtl/output_port_fifo.sv | 103 ++++++++++
 tb/tb_output_port_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/output_port_fifo.sv
// Output-port queue between the datapath bus and an external ready/valid consumer.
// Optional sticky drop flag enabled by defining OUTPUT_PORT_FIFO_OVERFLOW_EN.
module output_port_fifo #(
    parameter int                       DATA_WIDTH_IN  = 32,
    parameter int                       DATA_WIDTH_OUT = 32,
    parameter int                       DEPTH          = 4,
    parameter logic [DATA_WIDTH_IN-1:0] INIT           = 32'h0
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [DATA_WIDTH_IN-1:0]  BusMuxOut,
    output logic [DATA_WIDTH_OUT-1:0] External_Output,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
`ifdef OUTPUT_PORT_FIFO_OVERFLOW_EN
    ,
    output logic                      overflow
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH_OUT-1:0] INIT_OUT = INIT[DATA_WIDTH_OUT-1:0];
    localparam logic [CW-1:0]             DEPTH_C  = CW'(DEPTH);

    logic [DATA_WIDTH_OUT-1:0] mem [DEPTH];

    // Declaration initialisers give the post-clear state at power-up.
    logic [PW-1:0]             wr_ptr_reg = '0;
    logic [PW-1:0]             rd_ptr_reg = '0;
    logic [CW-1:0]             count_reg  = '0;
    logic [DATA_WIDTH_OUT-1:0] hold_reg   = INIT_OUT;

    logic push;
    logic pop;
    logic unused_bus;

    // Upper bus bits are intentionally discarded when the output is narrower.
    assign unused_bus = ^BusMuxOut;

    assign full      = (count_reg == DEPTH_C);
    assign empty     = (count_reg == '0);
    assign out_valid = ~empty;
    assign count     = count_reg;

    assign pop  = out_valid & out_ready & ~clear;
    assign push = enable & ~clear & (~full | pop);

    always_comb begin
        External_Output = hold_reg;
        if (!empty) begin
            External_Output = mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= BusMuxOut[DATA_WIDTH_OUT-1:0];
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            hold_reg   <= INIT_OUT;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
                hold_reg   <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef OUTPUT_PORT_FIFO_OVERFLOW_EN
    logic overflow_reg = 1'b0;

    always_ff @(posedge clock) begin
        if (clear) begin
            overflow_reg <= 1'b0;
        end else if (enable && full && !pop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_output_port_fifo.sv
// Table-driven bench for output_port_fifo with a queue scoreboard on every pop,
// plus a hand-written sequence on an 8-bit-output instance.
module tb_output_port_fifo;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] bus = '0;
    logic        out_ready = 1'b0;
    logic [31:0] ext_out;
    logic        out_valid, full, empty;
    logic [2:0]  count;

    logic        clear8 = 1'b0;
    logic        enable8 = 1'b0;
    logic [31:0] bus8 = '0;
    logic        ready8 = 1'b0;
    logic [7:0]  ext_out8;
    logic        valid8, full8, empty8;
    logic [2:0]  count8;

`ifdef OUTPUT_PORT_FIFO_OVERFLOW_EN
    logic ovf, ovf8;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    output_port_fifo #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(32), .DEPTH(4), .INIT(32'h0)) dut (
        .clock(clock), .clear(clear), .enable(enable), .BusMuxOut(bus),
        .External_Output(ext_out), .out_valid(out_valid), .out_ready(out_ready),
        .full(full), .empty(empty), .count(count)
`ifdef OUTPUT_PORT_FIFO_OVERFLOW_EN
        , .overflow(ovf)
`endif
    );

    output_port_fifo #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(8), .DEPTH(4), .INIT(32'h0)) dut8 (
        .clock(clock), .clear(clear8), .enable(enable8), .BusMuxOut(bus8),
        .External_Output(ext_out8), .out_valid(valid8), .out_ready(ready8),
        .full(full8), .empty(empty8), .count(count8)
`ifdef OUTPUT_PORT_FIFO_OVERFLOW_EN
        , .overflow(ovf8)
`endif
    );

    typedef struct {
        logic        clr;
        logic        en;
        logic        rdy;
        logic [31:0] din;
        int          exp_cnt;
        logic [31:0] exp_out;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        int          sz;
        logic        pop_m, push_m;
        logic        ovf_m;
        logic [31:0] head;
        ovf_m = 1'b0;

        // Power-up state before any clear.
        #1;
        chk("powerup_out", ext_out, 32'h0);
        chk("powerup_empty", 32'(empty), 32'd1);

        //            clr en rdy din           cnt out
        vecs.push_back('{1, 0, 0, 32'h0,  0, 32'h0});
        vecs.push_back('{0, 0, 0, 32'h0,  0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'hA1, 1, 32'hA1});
        vecs.push_back('{0, 1, 0, 32'hB2, 2, 32'hA1});
        vecs.push_back('{0, 1, 0, 32'hC3, 3, 32'hA1});
        vecs.push_back('{1, 0, 0, 32'h0,  0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h1,  1, 32'h1});
        vecs.push_back('{0, 1, 0, 32'h2,  2, 32'h1});
        vecs.push_back('{0, 1, 0, 32'h3,  3, 32'h1});
        vecs.push_back('{0, 1, 0, 32'h4,  4, 32'h1});
        vecs.push_back('{0, 1, 0, 32'h5,  4, 32'h1});
        vecs.push_back('{0, 0, 1, 32'h0,  3, 32'h2});
        vecs.push_back('{0, 0, 1, 32'h0,  2, 32'h3});
        vecs.push_back('{0, 0, 1, 32'h0,  1, 32'h4});
        vecs.push_back('{0, 0, 1, 32'h0,  0, 32'h4});
        vecs.push_back('{0, 0, 1, 32'h0,  0, 32'h4});
        vecs.push_back('{0, 1, 0, 32'h10, 1, 32'h10});
        vecs.push_back('{0, 1, 0, 32'h11, 2, 32'h10});
        vecs.push_back('{0, 1, 0, 32'h12, 3, 32'h10});
        vecs.push_back('{0, 1, 0, 32'h13, 4, 32'h10});
        vecs.push_back('{0, 1, 1, 32'h20, 4, 32'h11});
        vecs.push_back('{0, 1, 1, 32'h21, 4, 32'h12});
        vecs.push_back('{0, 1, 1, 32'h22, 4, 32'h13});
        vecs.push_back('{0, 1, 1, 32'h23, 4, 32'h20});
        vecs.push_back('{0, 1, 1, 32'h24, 4, 32'h21});
        vecs.push_back('{0, 1, 1, 32'h25, 4, 32'h22});
        vecs.push_back('{0, 0, 1, 32'h0,  3, 32'h23});
        vecs.push_back('{0, 0, 1, 32'h0,  2, 32'h24});
        vecs.push_back('{1, 1, 1, 32'h99, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h31, 1, 32'h31});
        vecs.push_back('{0, 1, 1, 32'h32, 1, 32'h32});
        vecs.push_back('{0, 0, 1, 32'h0,  0, 32'h32});

        @(negedge clock);
        for (int i = 0; i < vecs.size(); i++) begin
            sz     = sb.size();
            pop_m  = !vecs[i].clr && vecs[i].rdy && (sz > 0);
            push_m = !vecs[i].clr && vecs[i].en && ((sz < 4) || pop_m);
            if (pop_m) begin
                head = sb.pop_front();
                chk($sformatf("sb_pop[%0d]", i), ext_out, head);
            end
            if (push_m) sb.push_back(vecs[i].din);
            if (!vecs[i].clr && vecs[i].en && !push_m) ovf_m = 1'b1;
            if (vecs[i].clr) begin
                sb.delete();
                ovf_m = 1'b0;
            end

            clear     = vecs[i].clr;
            enable    = vecs[i].en;
            out_ready = vecs[i].rdy;
            bus       = vecs[i].din;
            @(posedge clock);
            @(negedge clock);

            $display("vec %0d clr=%0b en=%0b rdy=%0b din=%0h -> count=%0d out=%0h valid=%0b full=%0b",
                     i, vecs[i].clr, vecs[i].en, vecs[i].rdy, vecs[i].din, count, ext_out, out_valid, full);
            chk($sformatf("count[%0d]", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("out[%0d]", i), ext_out, vecs[i].exp_out);
            chk($sformatf("valid[%0d]", i), 32'(out_valid), 32'(sb.size() > 0));
            chk($sformatf("full[%0d]", i), 32'(full), 32'(sb.size() == 4));
            chk($sformatf("empty[%0d]", i), 32'(empty), 32'(sb.size() == 0));
`ifdef OUTPUT_PORT_FIFO_OVERFLOW_EN
            chk($sformatf("overflow[%0d]", i), 32'(ovf), 32'(ovf_m));
`endif
        end
        clear = 1'b0; enable = 1'b0; out_ready = 1'b0;

        // Narrow output: upper bus bits are discarded, hold keeps the narrow word.
        clear8 = 1'b1;
        @(posedge clock); @(negedge clock);
        clear8 = 1'b0; enable8 = 1'b1; bus8 = 32'h12345678;
        @(posedge clock); @(negedge clock);
        enable8 = 1'b0;
        $display("w8 push 12345678 -> out=%0h count=%0d", ext_out8, count8);
        chk("w8_out", 32'(ext_out8), 32'h78);
        chk("w8_count", 32'(count8), 32'd1);
        ready8 = 1'b1;
        @(posedge clock); @(negedge clock);
        ready8 = 1'b0;
        $display("w8 pop -> out=%0h empty=%0b", ext_out8, empty8);
        chk("w8_hold", 32'(ext_out8), 32'h78);
        chk("w8_empty", 32'(empty8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
